csa_chunked_adder_seq: RTL and testbench



---
 rtl/csa_chunked_adder_seq_pkg.sv | 29 ++
 rtl/csa_chunked_adder_seq_csa.sv | 34 +++
 rtl/csa_chunked_adder_seq.sv | 109 ++++++++++
 tb/tb_csa_chunked_adder_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/csa_chunked_adder_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : csa_chunked_adder_seq_pkg
//  Brief    : Shared FSM encoding and sizing helpers for the chunked adder.
//  Revision : 1.0  initial release
// ============================================================================
package csa_chunked_adder_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_RUN  = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Index counter needs at least one bit even for a single-chunk configuration.
    function automatic int calc_idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_chunked_adder_seq_csa.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder_Nbit_csa
//  Brief    : N-bit carry-skip adder; carry bypasses the ripple chain when
//             every bit propagates.
//  Revision : 1.0  initial release
// ============================================================================
module full_adder_Nbit_csa #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH:0]   w_c;

    assign w_p    = i_a ^ i_b;
    assign w_g    = i_a & i_b;
    assign w_c[0] = i_cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign w_c[gi+1]  = w_g[gi] | (w_p[gi] & w_c[gi]);
        assign o_sum[gi]  = w_p[gi] ^ w_c[gi];
    end

    assign o_cout = (&w_p) ? i_cin : w_c[WIDTH];

endmodule
`default_nettype wire

// File: rtl/csa_chunked_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : csa_chunked_adder_seq
//  Brief    : Multi-cycle WIDTH-bit adder feeding CHUNK bits per cycle,
//             LSB first, through a single carry-skip adder.
//  Revision : 1.0  initial release
// ============================================================================
module csa_chunked_adder_seq
    import csa_chunked_adder_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int c_IDXW   = calc_idx_width(c_NCHUNK);
    localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(c_NCHUNK - 1);

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
        $error("csa_chunked_adder_seq: WIDTH must be a positive multiple of CHUNK");
    end

    state_t              r_state;
    logic [c_IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_sum;
    logic                r_carry;

    logic [CHUNK-1:0]    w_a_chunk;
    logic [CHUNK-1:0]    w_b_chunk;
    logic [CHUNK-1:0]    w_sum_chunk;
    logic                w_cout_chunk;
    int unsigned         w_base;

    assign w_base    = int'(r_idx) * CHUNK;
    assign w_a_chunk = r_a[w_base +: CHUNK];
    assign w_b_chunk = r_b[w_base +: CHUNK];

    full_adder_Nbit_csa #(
        .WIDTH (CHUNK)
    ) u_csa (
        .i_a    (w_a_chunk),
        .i_b    (w_b_chunk),
        .i_cin  (r_carry),
        .o_sum  (w_sum_chunk),
        .o_cout (w_cout_chunk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    // The registered carry breaks the chain between chunks.
                    r_sum[w_base +: CHUNK] <= w_sum_chunk;
                    r_carry                <= w_cout_chunk;
                    if (r_idx == c_LAST) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_idx <= r_idx + c_IDXW'(1);
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_DONE);
    assign sum       = r_sum;
    assign cout      = r_carry;
    assign ovf       = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (r_sum[WIDTH-1] != r_a[WIDTH-1]);

endmodule
`default_nettype wire

// File: tb/tb_csa_chunked_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_chunked_adder_seq
//  Brief    : Directed self-checking bench with a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csa_chunked_adder_seq;

    localparam int c_WIDTH   = 32;
    localparam int c_CHUNK   = 4;
    localparam int c_LATENCY = c_WIDTH / c_CHUNK;

    typedef struct packed {
        logic [c_WIDTH-1:0] sum;
        logic               cout;
        logic               ovf;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [c_WIDTH-1:0] a;
    logic [c_WIDTH-1:0] b;
    logic               cin;
    logic               out_valid;
    logic               out_ready;
    logic [c_WIDTH-1:0] sum;
    logic               cout;
    logic               ovf;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    csa_chunked_adder_seq #(
        .WIDTH (c_WIDTH),
        .CHUNK (c_CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [c_WIDTH-1:0] xa, input logic [c_WIDTH-1:0] xb, input logic xc);
        exp_t             e;
        logic [c_WIDTH:0] t;
        t      = {1'b0, xa} + {1'b0, xb} + {{c_WIDTH{1'b0}}, xc};
        e.sum  = t[c_WIDTH-1:0];
        e.cout = t[c_WIDTH];
        e.ovf  = (xa[c_WIDTH-1] == xb[c_WIDTH-1]) && (t[c_WIDTH-1] != xa[c_WIDTH-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [c_WIDTH-1:0] xa, input logic [c_WIDTH-1:0] xb, input logic xc);
        @(negedge clk);
        check("in_ready_before_send", {63'd0, in_ready}, 64'd1);
        a        = xa;
        b        = xb;
        cin      = xc;
        in_valid = 1'b1;
        q_exp.push_back(model(xa, xb, xc));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid appears, bounded.
    task automatic wait_out(output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) break;
        end
        if (!out_valid) cyc = -1;
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (q_exp.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
        end else begin
            e = q_exp.pop_front();
            check({tag, "_sum"},  {32'd0, sum},  {32'd0, e.sum});
            check({tag, "_cout"}, {63'd0, cout}, {63'd0, e.cout});
            check({tag, "_ovf"},  {63'd0, ovf},  {63'd0, e.ovf});
        end
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_in_ready_after"},  {63'd0, in_ready},  64'd1);
        check({tag, "_out_valid_after"}, {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [c_WIDTH-1:0] xa, input logic [c_WIDTH-1:0] xb, input logic xc);
        int cyc;
        send(xa, xb, xc);
        wait_out(cyc);
        check({tag, "_latency"}, 64'(cyc), 64'(c_LATENCY));
        check_result(tag);
        drain(tag);
    endtask

    initial begin
        int   cyc;
        exp_t e1;
        logic seen;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Asynchronous reset asserted between clock edges.
        #12 rst_n = 1'b0;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_sum",       {32'd0, sum},       64'd0);
        check("rst_cout",      {63'd0, cout},      64'd0);
        check("rst_ovf",       {63'd0, ovf},       64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("ripple",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("cin",     32'h1234_5678, 32'h0FED_CBA9, 1'b1);

        // Backpressure in DONE with new operands already waiting.
        send(32'h1111_1111, 32'h2222_2222, 1'b0);
        wait_out(cyc);
        check("bp1_latency", 64'(cyc), 64'(c_LATENCY));
        e1       = q_exp[0];
        a        = 32'h0000_FFFF;
        b        = 32'h0000_0001;
        cin      = 1'b1;
        in_valid = 1'b1;
        q_exp.push_back(model(32'h0000_FFFF, 32'h0000_0001, 1'b1));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_in_ready",  {63'd0, in_ready},  64'd0);
            check("bp_hold_sum",       {32'd0, sum},       {32'd0, e1.sum});
            check("bp_hold_cout",      {63'd0, cout},      {63'd0, e1.cout});
            check("bp_hold_ovf",       {63'd0, ovf},       {63'd0, e1.ovf});
        end
        check_result("bp1");
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp_release_in_ready",  {63'd0, in_ready},  64'd1);
        check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        check("bp_accept_in_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        wait_out(cyc);
        check("bp2_latency", 64'(cyc), 64'(c_LATENCY));
        check_result("bp2");
        drain("bp2");

        // Reset pulse after three RUN edges aborts the operation.
        send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready",  {63'd0, in_ready},  64'd1);
        check("midrst_sum",       {32'd0, sum},       64'd0);
        check("midrst_cout",      {63'd0, cout},      64'd0);
        void'(q_exp.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_out_valid", {63'd0, seen},     64'd0);
        check("midrst_in_ready_rel", {63'd0, in_ready}, 64'd1);
        run_op("after_rst", 32'd5, 32'd7, 1'b0);

        check("scoreboard_drained", 64'(q_exp.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
